// File: rtl/pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_pkg
//  Description : Shared definitions for the UART frame packetizer: FSM state
//                encoding, CRC-8 polynomial and the default start-of-frame
//                byte. The CRC state exists only when PKT_CRC8_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package pkt_pkg;

  localparam logic [7:0] CRC8_POLY    = 8'h07;
  localparam logic [7:0] DEF_SOF_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_LEN  = 3'd2,
    ST_READ = 3'd3,
    ST_WAIT = 3'd4,
    ST_PAY  = 3'd5
`ifdef PKT_CRC8_EN
    , ST_CRC = 3'd6
`endif
  } state_t;

endpackage : pkt_pkg
`default_nettype wire

// File: rtl/crc8_update.sv
`default_nettype none
// ============================================================================
//  Module      : crc8_update
//  Description : Combinational byte-wide CRC-8 step (MSB first, no reflection,
//                no final XOR). Polynomial taken from pkt_pkg.
//  Ports       : crc_in  [7:0] - running CRC before this byte
//                data_in [7:0] - byte to fold in
//                crc_out [7:0] - running CRC after this byte
//  Revision    : 1.0 - initial release
// ============================================================================
module crc8_update
  import pkt_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  always_comb begin
    logic [7:0] w_c;
    w_c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[7] ? ((w_c << 1) ^ CRC8_POLY) : (w_c << 1);
    end
    crc_out = w_c;
  end

endmodule : crc8_update
`default_nettype wire

// File: rtl/uart_frame_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_packetizer
//  Description : Drains a byte FIFO into a UART transmitter as framed packets:
//                SOF_BYTE, LEN, LEN payload bytes [, CRC-8]. A full-size frame
//                launches as soon as MAX_PAYLOAD bytes are queued; a short frame
//                is flushed after TIMEOUT_CYC cycles of a non-empty FIFO.
//                Optional macro PKT_CRC8_EN appends a CRC-8 byte (poly 0x07,
//                init 0x00) computed over LEN and the payload.
//  Ports       : clk, rst (async, active-high)
//                fifo_empty, fifo_count, fifo_data, data_out_valid - FIFO side
//                rd_en - one-cycle FIFO read pulse
//                tx_busy, start_tx, tx_data - UART side
//                pkt_done - pulses with the launch of a frame's last byte
//                busy - high whenever the FSM is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_packetizer
  import pkt_pkg::*;
#(
  parameter int         MAX_PAYLOAD = 16,
  parameter logic [7:0] SOF_BYTE    = DEF_SOF_BYTE,
  parameter int         TIMEOUT_CYC = 1000,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [CNT_W-1:0] fifo_count,
  input  logic [7:0]       fifo_data,
  input  logic             data_out_valid,
  input  logic             tx_busy,
  output logic             rd_en,
  output logic             start_tx,
  output logic [7:0]       tx_data,
  output logic             pkt_done,
  output logic             busy
);

  localparam int             TMR_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     c_MAX_LEN  = 8'(MAX_PAYLOAD);

  // Where the FSM goes after the final payload byte, and whether that byte
  // closes the frame.
`ifdef PKT_CRC8_EN
  localparam state_t c_ST_AFTER_PAY = ST_CRC;
  localparam logic   c_DONE_ON_PAY  = 1'b0;
`else
  localparam state_t c_ST_AFTER_PAY = ST_IDLE;
  localparam logic   c_DONE_ON_PAY  = 1'b1;
`endif

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  logic [7:0]       r_len;
  logic [7:0]       r_cnt;
  logic [7:0]       r_byte;
  logic             r_guard;

  logic w_full;
  logic w_timeout;
  logic w_can_send;
  logic w_more;

  assign w_full     = (32'(fifo_count) >= 32'(MAX_PAYLOAD));
  assign w_timeout  = !fifo_empty && (r_timer == c_TMR_LAST);
  // tx_busy rises one cycle after start_tx; the guard covers that gap.
  assign w_can_send = !tx_busy && !r_guard;
  assign w_more     = ({1'b0, r_cnt} + 9'd1) < {1'b0, r_len};
  assign busy       = (r_state != ST_IDLE);

`ifdef PKT_CRC8_EN
  logic [7:0] r_crc;
  logic [7:0] w_crc_data;
  logic [7:0] w_crc_next;

  assign w_crc_data = (r_state == ST_LEN) ? r_len : r_byte;

  crc8_update u_crc8_update (
    .crc_in  (r_crc),
    .data_in (w_crc_data),
    .crc_out (w_crc_next)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_len    <= 8'h00;
      r_cnt    <= 8'h00;
      r_byte   <= 8'h00;
      r_guard  <= 1'b0;
      rd_en    <= 1'b0;
      start_tx <= 1'b0;
      tx_data  <= 8'h00;
      pkt_done <= 1'b0;
`ifdef PKT_CRC8_EN
      r_crc    <= 8'h00;
`endif
    end else begin
      rd_en    <= 1'b0;
      start_tx <= 1'b0;
      pkt_done <= 1'b0;
      r_guard  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // Full-size launch wins over timeout; LEN is frozen here.
          if (w_full || w_timeout) begin
            r_len   <= w_full ? c_MAX_LEN : 8'(fifo_count);
            r_timer <= '0;
            r_cnt   <= 8'h00;
`ifdef PKT_CRC8_EN
            r_crc   <= 8'h00;
`endif
            r_state <= ST_SOF;
          end else if (fifo_empty) begin
            r_timer <= '0;
          end else if (r_timer != c_TMR_LAST) begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end

        ST_SOF: begin
          if (w_can_send) begin
            start_tx <= 1'b1;
            tx_data  <= SOF_BYTE;
            r_guard  <= 1'b1;
            r_state  <= ST_LEN;
          end
        end

        ST_LEN: begin
          if (w_can_send) begin
            start_tx <= 1'b1;
            tx_data  <= r_len;
            r_guard  <= 1'b1;
`ifdef PKT_CRC8_EN
            r_crc    <= w_crc_next;
`endif
            if (r_len == 8'h00) begin
              r_state  <= c_ST_AFTER_PAY;
              pkt_done <= c_DONE_ON_PAY;
            end else begin
              r_state  <= ST_READ;
            end
          end
        end

        ST_READ: begin
          rd_en   <= 1'b1;
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (data_out_valid) begin
            r_byte  <= fifo_data;
            r_state <= ST_PAY;
          end
        end

        ST_PAY: begin
          if (w_can_send) begin
            start_tx <= 1'b1;
            tx_data  <= r_byte;
            r_guard  <= 1'b1;
            r_cnt    <= r_cnt + 8'd1;
`ifdef PKT_CRC8_EN
            r_crc    <= w_crc_next;
`endif
            if (w_more) begin
              r_state  <= ST_READ;
            end else begin
              r_state  <= c_ST_AFTER_PAY;
              pkt_done <= c_DONE_ON_PAY;
            end
          end
        end

`ifdef PKT_CRC8_EN
        ST_CRC: begin
          if (w_can_send) begin
            start_tx <= 1'b1;
            tx_data  <= r_crc;
            r_guard  <= 1'b1;
            pkt_done <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
`endif

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : uart_frame_packetizer
`default_nettype wire
